// File: rtl/eth_port_tx_if.sv
// Host write bus plus switch-port transmit bus for eth_port_tx.
// The master modport is the host/switch side; the slave modport is the transmitter.
interface eth_port_tx_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              port_stall;
    logic [DATA_W-1:0] tx_data;
    logic              tx_sop;
    logic              tx_eop;
    logic [CW-1:0]     pkt_pending;
    logic              err_drop;

    modport master (
        output wr_valid, wr_data, wr_last, port_stall,
        input  wr_ready, tx_data, tx_sop, tx_eop, pkt_pending, err_drop
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, port_stall,
        output wr_ready, tx_data, tx_sop, tx_eop, pkt_pending, err_drop
    );
endinterface

// File: rtl/eth_port_tx.sv
// Store-and-forward packet transmitter feeding one switch ingress port.
// Packets are buffered whole, then launched as a contiguous burst with a
// minimum inter-packet gap; oversize packets are discarded.
module eth_port_tx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IPG    = 2
) (
    input  logic         clk,
    input  logic         reset,
    eth_port_tx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (IPG > 1) ? $clog2(IPG) : 1;

    typedef enum logic       {W_ACCEPT, W_DROP} wstate_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tstate_t;

    // Each entry holds {last, data} so the reader knows where the packet ends.
    logic [DATA_W:0] mem_q [DEPTH];

    wstate_t         wst_q, wst_d;
    tstate_t         tst_q, tst_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   pkt_start_q, pkt_start_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   part_q, part_d;
    logic [CW-1:0]   pend_q, pend_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic            tx_sop_q, tx_sop_d;
    logic            tx_eop_q, tx_eop_d;
    logic            err_q, err_d;

    logic            wr_ready;
    logic            beat, store, ovf, pkt_done;
    logic            can_start, launch, rd;
    logic [DATA_W:0] rd_word;

    // Ready depends on registered occupancy only; a read this cycle does not free space until next.
    assign wr_ready = (wst_q == W_DROP) || (occ_q < CW'(DEPTH));
    assign beat     = bus.wr_valid && wr_ready;
    assign store    = beat && (wst_q == W_ACCEPT);
    // The beat that would make the partial packet DEPTH words long without ending it.
    assign ovf      = store && !bus.wr_last && (part_q == CW'(DEPTH - 1));
    assign rd_word  = mem_q[rd_ptr_q];

    assign bus.wr_ready    = wr_ready;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_sop      = tx_sop_q;
    assign bus.tx_eop      = tx_eop_q;
    assign bus.pkt_pending = pend_q;
    assign bus.err_drop    = err_q;

    // Buffer storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= {bus.wr_last, bus.wr_data};
    end

    // Write side: accept words, close packets on last, rewind and drop oversize packets.
    always_comb begin
        wst_d       = wst_q;
        wr_ptr_d    = wr_ptr_q;
        pkt_start_d = pkt_start_q;
        part_d      = part_q;
        err_d       = 1'b0;
        pkt_done    = 1'b0;
        case (wst_q)
            W_ACCEPT: begin
                if (store) begin
                    if (bus.wr_last) begin
                        pkt_done    = 1'b1;
                        wr_ptr_d    = wr_ptr_q + 1'b1;
                        pkt_start_d = wr_ptr_q + 1'b1;
                        part_d      = '0;
                    end else if (ovf) begin
                        wr_ptr_d = pkt_start_q;
                        part_d   = '0;
                        err_d    = 1'b1;
                        wst_d    = W_DROP;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        part_d   = part_q + 1'b1;
                    end
                end
            end
            W_DROP: begin
                if (beat && bus.wr_last) wst_d = W_ACCEPT;
            end
            default: wst_d = W_ACCEPT;
        endcase
    end

    // Tx side: launch whole packets at boundaries, stream them, then hold the gap.
    always_comb begin
        tst_d     = tst_q;
        gap_d     = gap_q;
        tx_data_d = '0;
        tx_sop_d  = 1'b0;
        tx_eop_d  = 1'b0;
        rd        = 1'b0;
        // A new packet may start from idle, the last gap cycle, or straight after eop when IPG is 0.
        can_start = (tst_q == T_IDLE) ||
                    ((tst_q == T_GAP) && (gap_q == '0)) ||
                    ((tst_q == T_SEND) && tx_eop_q && (IPG == 0));
        launch    = can_start && (pend_q != '0) && !bus.port_stall;
        if (launch) begin
            rd        = 1'b1;
            tx_data_d = rd_word[DATA_W-1:0];
            tx_sop_d  = 1'b1;
            tx_eop_d  = rd_word[DATA_W];
            tst_d     = T_SEND;
        end else begin
            case (tst_q)
                T_SEND: begin
                    if (tx_eop_q) begin
                        if (IPG > 0) begin
                            tst_d = T_GAP;
                            gap_d = GW'(IPG - 1);
                        end else begin
                            tst_d = T_IDLE;
                        end
                    end else begin
                        rd        = 1'b1;
                        tx_data_d = rd_word[DATA_W-1:0];
                        tx_eop_d  = rd_word[DATA_W];
                    end
                end
                T_GAP: begin
                    if (gap_q == '0) tst_d = T_IDLE;
                    else             gap_d = gap_q - 1'b1;
                end
                default: tst_d = T_IDLE;
            endcase
        end
        rd_ptr_d = rd_ptr_q + AW'(rd);
        // Oversize drop returns DEPTH words, including the one stored this beat.
        occ_d    = occ_q + CW'(store) - CW'(rd) - (ovf ? CW'(DEPTH) : CW'(0));
        pend_d   = pend_q + CW'(pkt_done) - CW'(launch);
    end

    // State registers; reset discards every buffered word and idles the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wst_q       <= W_ACCEPT;
            tst_q       <= T_IDLE;
            wr_ptr_q    <= '0;
            pkt_start_q <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            part_q      <= '0;
            pend_q      <= '0;
            gap_q       <= '0;
            tx_data_q   <= '0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wst_q       <= wst_d;
            tst_q       <= tst_d;
            wr_ptr_q    <= wr_ptr_d;
            pkt_start_q <= pkt_start_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            part_q      <= part_d;
            pend_q      <= pend_d;
            gap_q       <= gap_d;
            tx_data_q   <= tx_data_d;
            tx_sop_q    <= tx_sop_d;
            tx_eop_q    <= tx_eop_d;
            err_q       <= err_d;
        end
    end
endmodule
